// File: rtl/rotary_encoder_mc_pkg.sv
// Shared definitions for the multi-channel rotary encoder core: register map,
// CTRL bit positions, decode mode and the quadrature step classifier.
package rotary_encoder_mc_pkg;

  // Register byte offsets
  localparam int REG_CTRL_OFS   = 'h00;
  localparam int REG_STATUS_OFS = 'h04;
  localparam int REG_BTN_OFS    = 'h08;
  localparam int REG_COUNT_OFS  = 'h10;

  // CTRL bit indices
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MODE_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int CTRL_W          = 3;

  // STATUS layout: chg in the low half, err in the high half
  localparam int STATUS_ERR_LSB = 16;

  typedef enum logic {
    MODE_X1 = 1'b0,
    MODE_X4 = 1'b1
  } mode_e;

  // Encoded so that (new_index - last_index) mod 4 maps straight onto the enum.
  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_INC     = 2'd1,
    STEP_ILLEGAL = 2'd2,
    STEP_DEC     = 2'd3
  } step_e;

  // Position of an AB pair along the CW sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_index(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic step_e quad_step(input logic [1:0] last_ab, input logic [1:0] new_ab);
    logic [1:0] diff;
    diff = gray_index(new_ab) - gray_index(last_ab);
    return step_e'(diff);
  endfunction

endpackage

// File: rtl/rotary_encoder_channel.sv
// One encoder channel: 2-FF synchroniser, debouncer for A/B/button,
// quadrature decoder and signed position counter.
module rotary_encoder_channel
  import rotary_encoder_mc_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             btn_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             chg_o,
  output logic             err_o,
  output logic             btn_rise_o
);

  localparam int N_SIG = 3;

  logic [N_SIG-1:0] raw;
  logic [N_SIG-1:0] sync1_q;
  logic [N_SIG-1:0] sync2_q;
  logic [N_SIG-1:0] deb;

  assign raw = {btn_i, a_i, b_i};

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  if (DEB_CYCLES == 0) begin : g_no_deb
    assign deb = sync2_q;
  end else begin : g_deb
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [N_SIG-1:0]         deb_q;
    logic [N_SIG-1:0]         deb_d;
    logic [N_SIG-1:0][DW-1:0] cnt_q;
    logic [N_SIG-1:0][DW-1:0] cnt_d;

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int i = 0; i < N_SIG; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == DEB_LAST) begin
            deb_d[i] = sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + DW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_q <= '0;
        cnt_q <= '0;
      end else begin
        deb_q <= deb_d;
        cnt_q <= cnt_d;
      end
    end

    assign deb = deb_q;
  end

  logic [1:0]       ab;
  logic [1:0]       last_ab_q;
  logic             btn_prev_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  step_e            step;
  logic             cnt_up;
  logic             cnt_dn;

  assign ab = deb[1:0];

  // x1 only counts across the 10/00 boundary, one count per detent cycle.
  always_comb begin
    step   = quad_step(last_ab_q, ab);
    cnt_up = 1'b0;
    cnt_dn = 1'b0;
    if (en_i) begin
      case (step)
        STEP_INC: cnt_up = (mode_i == MODE_X4) || (last_ab_q == 2'b10);
        STEP_DEC: cnt_dn = (mode_i == MODE_X4) || (last_ab_q == 2'b00);
        default:  ;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (cnt_up) begin
      count_d = count_q + CNT_W'(1);
    end else if (cnt_dn) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // last AB tracks even while disabled so re-enabling sees no stale step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ab_q  <= 2'b00;
      btn_prev_q <= 1'b0;
      count_q    <= '0;
    end else begin
      last_ab_q  <= ab;
      btn_prev_q <= deb[2];
      count_q    <= count_d;
    end
  end

  assign count_o    = count_q;
  assign chg_o      = (cnt_up | cnt_dn) & ~load_i;
  assign err_o      = en_i & (step == STEP_ILLEGAL);
  assign btn_rise_o = deb[2] & ~btn_prev_q;

endmodule

// File: rtl/rotary_encoder_mc_core.sv
// Multi-channel quadrature encoder core: channel array, register file with
// single-cycle write / one-cycle-latency read, sticky status and level irq.
module rotary_encoder_mc_core
  import rotary_encoder_mc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 1000,
  parameter int ADDR_W     = 8
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic [N_CH-1:0]   enc_a,
  input  logic [N_CH-1:0]   enc_b,
  input  logic [N_CH-1:0]   enc_btn,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_rvalid,
  output logic              irq
);

  localparam int WORD_W = ADDR_W - 2;
  localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(REG_CTRL_OFS / 4);
  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(REG_STATUS_OFS / 4);
  localparam logic [WORD_W-1:0] W_BTN    = WORD_W'(REG_BTN_OFS / 4);

  logic              clk;
  logic              rst_n;
  logic [WORD_W-1:0] word;
  logic              wr_ctrl;
  logic              wr_status;
  logic              wr_btn;
  logic              unused_ok;

  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;
  assign word  = reg_addr[ADDR_W-1:2];

  assign wr_ctrl   = reg_wr && (word == W_CTRL);
  assign wr_status = reg_wr && (word == W_STATUS);
  assign wr_btn    = reg_wr && (word == W_BTN);

  // Byte lanes below the word and write-data bits above the used fields are ignored.
  assign unused_ok = ^{reg_addr[1:0], reg_wdata};

  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic [N_CH-1:0]   chg_q, chg_d, chg_set;
  logic [N_CH-1:0]   err_q, err_d, err_set;
  logic [N_CH-1:0]   btn_q, btn_d, btn_set;
  logic [N_CH-1:0]   load;
  logic [31:0]       count_ext [N_CH];
  mode_e             mode;

  assign mode = mode_e'(ctrl_q[CTRL_MODE_BIT]);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] count;

    assign load[ch] = reg_wr && (word == WORD_W'(REG_COUNT_OFS / 4 + ch));

    rotary_encoder_channel #(
      .CNT_W      (CNT_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_i        (enc_a[ch]),
      .b_i        (enc_b[ch]),
      .btn_i      (enc_btn[ch]),
      .en_i       (ctrl_q[CTRL_EN_BIT]),
      .mode_i     (mode),
      .load_i     (load[ch]),
      .load_val_i (reg_wdata[CNT_W-1:0]),
      .count_o    (count),
      .chg_o      (chg_set[ch]),
      .err_o      (err_set[ch]),
      .btn_rise_o (btn_set[ch])
    );

    assign count_ext[ch] = 32'($signed(count));
  end

  // Clear is applied before set, so a simultaneous new event survives the W1C.
  always_comb begin
    ctrl_d = wr_ctrl ? reg_wdata[CTRL_W-1:0] : ctrl_q;
    chg_d  = chg_q;
    err_d  = err_q;
    btn_d  = btn_q;
    if (wr_status) begin
      chg_d = chg_d & ~reg_wdata[N_CH-1:0];
      err_d = err_d & ~reg_wdata[STATUS_ERR_LSB +: N_CH];
    end
    if (wr_btn) begin
      btn_d = btn_d & ~reg_wdata[N_CH-1:0];
    end
    chg_d = chg_d | chg_set;
    err_d = err_d | err_set;
    btn_d = btn_d | btn_set;
  end

  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = '0;
    if (word == W_CTRL) begin
      rdata_d[CTRL_W-1:0] = ctrl_q;
    end else if (word == W_STATUS) begin
      rdata_d[N_CH-1:0]                = chg_q;
      rdata_d[STATUS_ERR_LSB +: N_CH]  = err_q;
    end else if (word == W_BTN) begin
      rdata_d[N_CH-1:0] = btn_q;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (word == WORD_W'(REG_COUNT_OFS / 4 + i)) begin
          rdata_d = count_ext[i];
        end
      end
    end
  end

  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        irq_q;
  logic        irq_d;

  assign irq_d = ctrl_q[CTRL_IRQ_EN_BIT] & ((|chg_q) | (|err_q) | (|btn_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      chg_q    <= '0;
      err_q    <= '0;
      btn_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
      btn_q    <= btn_d;
      rvalid_q <= reg_rd;
      irq_q    <= irq_d;
      if (reg_rd) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_rotary_encoder_mc_core.sv
// Randomised self-checking bench for rotary_encoder_mc_core against a
// phase/position reference model of the encoders and the register map.
module tb_rotary_encoder_mc_core;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;
  localparam int DEB    = 8;
  localparam int ADDR_W = 8;
  localparam int SETTLE = DEB + 6;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_BTN    = 8'h08;
  localparam logic [7:0] A_COUNT  = 8'h10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   enc_a, enc_b, enc_btn;
  logic              reg_wr, reg_rd;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic              reg_rvalid;
  logic              irq;

  always #5 clk = ~clk;

  rotary_encoder_mc_core #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .DEB_CYCLES (DEB),
    .ADDR_W     (ADDR_W)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .enc_a           (enc_a),
    .enc_b           (enc_b),
    .enc_btn         (enc_btn),
    .reg_wr          (reg_wr),
    .reg_rd          (reg_rd),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata),
    .reg_rvalid      (reg_rvalid),
    .irq             (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: shaft phase (0..3 along the CW sequence) and position.
  int              m_phase [N_CH];
  int              m_cnt   [N_CH];
  logic [N_CH-1:0] m_chg, m_err, m_btn;
  logic            m_en, m_x4;

  function automatic logic [1:0] phase_ab(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] sext(input int v);
    logic signed [CNT_W-1:0] t;
    t = CNT_W'(v);
    return 32'(t);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[N_CH-1:0]  = m_chg;
    s[16 +: N_CH] = m_err;
    return s;
  endfunction

  task automatic drive_phase(input int ch);
    logic [1:0] ab;
    ab = phase_ab(m_phase[ch]);
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    @(negedge clk);
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic write_ctrl(input logic [2:0] v);
    reg_write(A_CTRL, {29'd0, v});
    m_en = v[0];
    m_x4 = v[1];
  endtask

  task automatic write_count(input int ch, input int v);
    reg_write(A_COUNT + 8'(4 * ch), 32'(v));
    m_cnt[ch] = v;
  endtask

  task automatic clear_status(input logic [31:0] mask);
    reg_write(A_STATUS, mask);
    m_chg = m_chg & ~mask[N_CH-1:0];
    m_err = m_err & ~mask[16 +: N_CH];
  endtask

  // Move one detent position in direction dir (+1 CW / -1 CCW), apply model rules.
  task automatic step_pins(input int ch, input int dir);
    int old_p;
    old_p = m_phase[ch];
    m_phase[ch] = (old_p + dir) & 3;
    drive_phase(ch);
    if (m_en && (m_x4 || (dir > 0 && old_p == 3) || (dir < 0 && old_p == 0))) begin
      m_cnt[ch] = m_cnt[ch] + dir;
      m_chg[ch] = 1'b1;
    end
  endtask

  task automatic step(input int ch, input int dir);
    step_pins(ch, dir);
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic illegal(input int ch);
    m_phase[ch] = (m_phase[ch] + 2) & 3;
    drive_phase(ch);
    if (m_en) m_err[ch] = 1'b1;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic glitch(input int ch, input bit on_a);
    if (on_a) enc_a[ch] = ~enc_a[ch]; else enc_b[ch] = ~enc_b[ch];
    repeat (DEB / 2) @(negedge clk);
    drive_phase(ch);
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic check_count(input string tag, input int ch);
    logic [31:0] d;
    reg_read(A_COUNT + 8'(4 * ch), d);
    check(tag, d, sext(m_cnt[ch]));
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    reg_read(A_STATUS, d);
    check(tag, d, exp_status());
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    m_chg = '0; m_err = '0; m_btn = '0;
    m_en = 1'b0; m_x4 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] d;
    reg_read(A_CTRL, d);   check({tag, "_ctrl"}, d, 32'h0);
    reg_read(A_STATUS, d); check({tag, "_status"}, d, 32'h0);
    reg_read(A_BTN, d);    check({tag, "_btn"}, d, 32'h0);
    for (int i = 0; i < N_CH; i++) begin
      reg_read(A_COUNT + 8'(4 * i), d);
      check($sformatf("%s_count%0d", tag, i), d, 32'h0);
    end
    check({tag, "_irq"}, {31'd0, irq}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    enc_a = '0; enc_b = '0; enc_btn = '0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    for (int i = 0; i < N_CH; i++) m_phase[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_rvalid", {31'd0, reg_rvalid}, 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);
    check_all_zero("rst");

    // x4 CW on ch0
    write_ctrl(3'b011);
    for (int i = 0; i < 8; i++) step(0, 1);
    reg_read(A_COUNT, d);
    check("x4_cw_count0", d, 32'h0000_0008);
    reg_read(A_STATUS, d);
    check("x4_cw_status", d, 32'h0000_0001);
    clear_status(32'hFFFF_FFFF);

    // x1 CCW, two full cycles on ch2
    write_ctrl(3'b001);
    for (int i = 0; i < 8; i++) step(2, -1);
    reg_read(A_COUNT + 8'h08, d);
    check("x1_ccw_count2", d, 32'hFFFF_FFFE);
    check_count("x1_other0", 0);
    check_count("x1_other1", 1);
    check_count("x1_other3", 3);

    // Wrap at the signed boundary
    write_ctrl(3'b011);
    write_count(1, 'h7FFF);
    step(1, 1);
    reg_read(A_COUNT + 8'h04, d);
    check("wrap_up", d, 32'hFFFF_8000);
    step(1, -1);
    reg_read(A_COUNT + 8'h04, d);
    check("wrap_down", d, 32'h0000_7FFF);
    clear_status(32'hFFFF_FFFF);

    // Glitch rejection and illegal transition on ch3
    glitch(3, 1'b1);
    check_count("glitch_count3", 3);
    check_status("glitch_status");
    illegal(3);
    reg_read(A_STATUS, d);
    check("illegal_err3", d, 32'h0008_0000);
    check_count("illegal_count3", 3);
    clear_status(32'h0008_0000);
    check_status("err_w1c");

    // Button capture, irq, W1C colliding with a new press
    write_ctrl(3'b111);
    enc_btn[1] = 1'b1;
    m_btn[1] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    reg_read(A_BTN, d);
    check("btn1_set", d, 32'h0000_0002);
    check("btn_irq", {31'd0, irq}, 32'h1);
    enc_btn[0] = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    reg_write(A_BTN, 32'h0000_0003);
    repeat (4) @(negedge clk);
    reg_read(A_BTN, d);
    check("btn_set_wins", d, 32'h0000_0001);
    check("btn_irq_held", {31'd0, irq}, 32'h1);
    enc_btn = '0;
    repeat (SETTLE) @(negedge clk);
    reg_read(A_BTN, d);
    check("btn_no_fall_evt", d, 32'h0000_0001);
    reg_write(A_BTN, 32'hFFFF_FFFF);
    m_btn = '0;
    clear_status(32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'h0);

    // COUNT write colliding with a step: the write wins
    write_ctrl(3'b011);
    step_pins(0, 1);
    repeat (DEB + 2) @(negedge clk);
    write_count(0, 'h1234);
    repeat (SETTLE) @(negedge clk);
    reg_read(A_COUNT, d);
    check("load_wins", d, 32'h0000_1234);
    clear_status(32'hFFFF_FFFF);

    // Read latency, rdata hold, read-before-write in the same cycle
    @(negedge clk);
    check("rvalid_idle", {31'd0, reg_rvalid}, 32'h0);
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = A_CTRL; reg_wdata = 32'h1;
    @(negedge clk);
    reg_rd = 1'b0; reg_wr = 1'b0;
    m_en = 1'b1; m_x4 = 1'b0;
    check("rvalid_pulse", {31'd0, reg_rvalid}, 32'h1);
    check("rd_pre_write", reg_rdata, 32'h0000_0003);
    @(negedge clk);
    check("rvalid_one_cycle", {31'd0, reg_rvalid}, 32'h0);
    check("rdata_hold", reg_rdata, 32'h0000_0003);
    reg_read(A_CTRL, d);
    check("ctrl_after_write", d, 32'h0000_0001);
    reg_read(8'h0C, d);
    check("unmapped_0c", d, 32'h0);
    reg_read(8'h40, d);
    check("unmapped_40", d, 32'h0);

    // Randomised operation against the model
    for (int it = 0; it < 80; it++) begin
      int ch;
      int op;
      ch = $urandom_range(0, N_CH - 1);
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) write_ctrl({1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
      if (op < 4)       step(ch, 1);
      else if (op < 8)  step(ch, -1);
      else if (op == 8) glitch(ch, 1'($urandom_range(0, 1)));
      else              illegal(ch);
      if ($urandom_range(0, 2) == 0) check_count($sformatf("rnd%0d_count%0d", it, ch), ch);
      if (it % 10 == 9) begin
        check_status($sformatf("rnd%0d_status", it));
        clear_status($urandom);
      end
    end
    for (int i = 0; i < N_CH; i++) check_count($sformatf("rnd_final_count%0d", i), i);
    check_status("rnd_final_status");

    // Reset in the middle of a rotation
    write_ctrl(3'b011);
    step_pins(0, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("inrst_rvalid", {31'd0, reg_rvalid}, 32'h0);
    check("inrst_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("post_rst_rdata", reg_rdata, 32'h0);
    repeat (SETTLE) @(negedge clk);
    check_all_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
